uart_mmio_fifo: RTL and testbench

- Memory-mapped UART controller for the CPU memory stage, with parametrised TX and RX byte FIFOs.
- Decodes a 4-word I/O window and returns registered read data.
- Drives a byte-level valid/ready UART core (the UART core is external to this block).
- Adds over the single-byte interface: buffering, occupancy counts, sticky overflow/drop flags, and a control register.

---
 rtl/uart_mmio_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART controller: a 4-word I/O window in front of TX and RX
// byte FIFOs that talk to an external byte-level valid/ready UART core.
module uart_mmio_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned TX_DEPTH  = 8,
  parameter int unsigned RX_DEPTH  = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        WriteEn,
  input  logic        ReadEn,
  output logic [31:0] ReadData,
  output logic [7:0]  TxData,
  output logic        TxValid,
  input  logic        TxReady,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW+1)'(TX_DEPTH);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_RXDATA = 2'd1,
    REG_TXDATA = 2'd2,
    REG_CTRL   = 2'd3
  } reg_e;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [TX_AW:0]   tx_count;
  logic [RX_AW:0]   rx_count;
  logic             rx_overflow, tx_drop;

  logic        hit;
  reg_e        reg_sel;
  logic        rd_rx, wr_tx, wr_ctrl, flush;
  logic        tx_full, rx_nonempty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        tx_drop_set, rx_ovf_set;
  logic [31:0] status_word, read_mux;

  assign hit     = (Addr[31:4] == BASE_ADDR[31:4]) && (Addr[1:0] == 2'b00);
  assign reg_sel = reg_e'(Addr[3:2]);
  assign rd_rx   = ReadEn  && hit && (reg_sel == REG_RXDATA);
  assign wr_tx   = WriteEn && hit && (reg_sel == REG_TXDATA);
  assign wr_ctrl = WriteEn && hit && (reg_sel == REG_CTRL);
  assign flush   = wr_ctrl && WriteData[2];

  assign tx_full     = (tx_count == TX_FULL_CNT);
  assign rx_nonempty = (rx_count != '0);

  assign TxValid = (tx_count != '0);
  assign TxData  = tx_mem[tx_rd_ptr];
  assign RxReady = 1'b1;

  // A full FIFO still accepts a push when it frees a slot in the same cycle.
  assign tx_pop      = TxValid && TxReady;
  assign tx_push     = wr_tx && (!tx_full || tx_pop);
  assign tx_drop_set = wr_tx && !tx_push && !flush;
  assign rx_pop      = rd_rx && rx_nonempty;
  assign rx_push     = RxValid && ((rx_count != RX_FULL_CNT) || rx_pop);
  assign rx_ovf_set  = RxValid && !rx_push && !flush;

  // STATUS word and load-data mux, both built from pre-update state
  always_comb begin
    status_word        = '0;
    status_word[0]     = !tx_full;
    status_word[1]     = rx_nonempty;
    status_word[2]     = rx_overflow;
    status_word[3]     = tx_drop;
    status_word[15:8]  = 8'(rx_count);
    status_word[23:16] = 8'(tx_count);
    read_mux = '0;
    if (hit) begin
      case (reg_sel)
        REG_STATUS: read_mux = status_word;
        REG_RXDATA: read_mux = rx_nonempty ? {24'b0, rx_mem[rx_rd_ptr]} : '0;
        default:    read_mux = '0;
      endcase
    end
  end

  // Registered load result, held between loads
  always_ff @(posedge Clock) begin
    if (Reset)       ReadData <= '0;
    else if (ReadEn) ReadData <= read_mux;
  end

  // FIFO storage, intentionally not reset
  always_ff @(posedge Clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= WriteData[7:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= RxData;
  end

  // TX pointers and occupancy; flush overrides same-cycle push/pop
  always_ff @(posedge Clock) begin
    if (Reset || flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_AW+1)'(1);
        2'b01:   tx_count <= tx_count - (TX_AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX pointers and occupancy; flush overrides same-cycle push/pop
  always_ff @(posedge Clock) begin
    if (Reset || flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
        2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Sticky error flags; a same-cycle set beats a CTRL clear
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rx_overflow <= 1'b0;
      tx_drop     <= 1'b0;
    end else begin
      if (rx_ovf_set)                    rx_overflow <= 1'b1;
      else if (wr_ctrl && WriteData[0])  rx_overflow <= 1'b0;
      if (tx_drop_set)                   tx_drop <= 1'b1;
      else if (wr_ctrl && WriteData[1])  tx_drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Scoreboard bench for uart_mmio_fifo: expected load results and TX bytes are
// queued when stimulus is issued and compared when the DUT produces them.
module tb_uart_mmio_fifo;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = BASE;
  localparam logic [31:0] A_RXDATA = BASE + 32'h4;
  localparam logic [31:0] A_TXDATA = BASE + 32'h8;
  localparam logic [31:0] A_CTRL   = BASE + 32'hC;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic        WriteEn = 1'b0;
  logic        ReadEn = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady = 1'b0;
  logic [7:0]  RxData = '0;
  logic        RxValid = 1'b0;
  logic        RxReady;

  uart_mmio_fifo #(.BASE_ADDR(BASE), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .Clock(Clock), .Reset(Reset), .Addr(Addr), .WriteData(WriteData),
    .WriteEn(WriteEn), .ReadEn(ReadEn), .ReadData(ReadData),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
    .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady)
  );

  always #5 Clock = ~Clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] rd_q[$];
  string       rd_tag[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_model[$];
  logic        rd_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: inputs change just after rising edges
  always @(negedge Clock) begin
    if (rd_pend) begin
      check("rd_sb_nonempty", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) check(rd_tag.pop_front(), ReadData, rd_q.pop_front());
    end
    rd_pend = ReadEn;
    if (TxValid && TxReady) begin
      check("tx_sb_nonempty", 32'(tx_q.size() != 0), 32'd1);
      if (tx_q.size() != 0) check("tx_byte", 32'(TxData), 32'(tx_q.pop_front()));
    end
  end

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(posedge Clock); #2;
    Addr = a; ReadEn = 1'b1;
    rd_q.push_back(exp); rd_tag.push_back(tag);
    @(posedge Clock); #2;
    ReadEn = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge Clock); #2;
    Addr = a; WriteData = d; WriteEn = 1'b1;
    @(posedge Clock); #2;
    WriteEn = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b);
    @(posedge Clock); #2;
    RxData = b; RxValid = 1'b1;
    if (rx_model.size() < 8) rx_model.push_back(b);
    @(posedge Clock); #2;
    RxValid = 1'b0;
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] exp;
    exp = (rx_model.size() != 0) ? {24'b0, rx_model.pop_front()} : 32'd0;
    rd(A_RXDATA, exp, tag);
  endtask

  task automatic drain_tx();
    @(posedge Clock); #2;
    TxReady = 1'b1;
    for (int i = 0; i < 40 && tx_q.size() != 0; i++) @(negedge Clock);
    check("tx_drained", 32'(tx_q.size()), 32'd0);
    @(posedge Clock); #2;
    check("txvalid_idle", 32'(TxValid), 32'd0);
    TxReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge Clock);
    #2 Reset = 1'b0;
    check("reset_readdata", ReadData, 32'd0);
    check("reset_txvalid", 32'(TxValid), 32'd0);
    check("reset_rxready", 32'(RxReady), 32'd1);

    // Reset state and address decode
    rd(A_STATUS, 32'h0000_0001, "status_reset");
    rd(BASE + 32'h10, 32'd0, "unmapped_next_window");
    rd(BASE + 32'h1, 32'd0, "unaligned");
    rd(A_CTRL, 32'd0, "ctrl_read");
    wr(BASE + 32'h18, 32'h99);

    // TX buffering then in-order drain
    foreach (tx_q[i]) tx_q.delete();
    for (int i = 0; i < 3; i++) begin
      wr(A_TXDATA, 32'h41 + 32'(i));
      tx_q.push_back(8'h41 + 8'(i));
    end
    rd(A_STATUS, 32'h0003_0001, "status_tx3");
    drain_tx();

    // TX overfill: ninth byte dropped, tx_drop sticky then cleared
    for (int i = 0; i < 9; i++) begin
      wr(A_TXDATA, 32'h10 + 32'(i));
      if (i < 8) tx_q.push_back(8'h10 + 8'(i));
    end
    rd(A_STATUS, 32'h0008_0008, "status_tx_full_drop");
    wr(A_CTRL, 32'h2);
    rd(A_STATUS, 32'h0008_0000, "status_drop_cleared");
    drain_tx();

    // RX receive and pop, including pop from empty
    rx_send(8'h55);
    rx_send(8'hAA);
    rd(A_STATUS, 32'h0000_0203, "status_rx2");
    read_rx("rx_pop1");
    read_rx("rx_pop2");
    read_rx("rx_pop_empty");
    rd(A_STATUS, 32'h0000_0001, "status_rx_empty");

    // RX overflow, sticky priority, simultaneous push/pop at full
    for (int i = 0; i < 9; i++) rx_send(8'h60 + 8'(i));
    rd(A_STATUS, 32'h0000_0807, "status_rx_overflow");
    @(posedge Clock); #2;
    Addr = A_CTRL; WriteData = 32'h1; WriteEn = 1'b1; RxData = 8'hEE; RxValid = 1'b1;
    @(posedge Clock); #2;
    WriteEn = 1'b0; RxValid = 1'b0;
    rd(A_STATUS, 32'h0000_0807, "sticky_set_beats_clear");
    wr(A_CTRL, 32'h1);
    rd(A_STATUS, 32'h0000_0803, "status_ovf_cleared");
    @(posedge Clock); #2;
    Addr = A_RXDATA; ReadEn = 1'b1; RxData = 8'h69; RxValid = 1'b1;
    rd_q.push_back({24'b0, rx_model.pop_front()}); rd_tag.push_back("rx_pushpop_head");
    rx_model.push_back(8'h69);
    @(posedge Clock); #2;
    ReadEn = 1'b0; RxValid = 1'b0;
    rd(A_STATUS, 32'h0000_0803, "status_after_pushpop");
    for (int i = 0; i < 8; i++) read_rx("rx_drain");
    rd(A_STATUS, 32'h0000_0001, "status_rx_drained");

    // Flush both FIFOs
    for (int i = 0; i < 4; i++) wr(A_TXDATA, 32'hC0 + 32'(i));
    for (int i = 0; i < 4; i++) rx_send(8'hD0 + 8'(i));
    rd(A_STATUS, 32'h0004_0403, "status_pre_flush");
    wr(A_CTRL, 32'h4);
    rx_model.delete();
    rd(A_STATUS, 32'h0000_0001, "status_flushed");
    check("txvalid_flushed", 32'(TxValid), 32'd0);
    read_rx("rx_after_flush");

    // Reset mid-transfer discards buffered bytes
    wr(A_TXDATA, 32'h77);
    rx_send(8'h88);
    rd(A_STATUS, 32'h0001_0103, "status_pre_reset");
    @(posedge Clock); #2;
    Reset = 1'b1;
    @(posedge Clock); #2;
    Reset = 1'b0;
    rx_model.delete();
    check("midreset_readdata", ReadData, 32'd0);
    check("midreset_txvalid", 32'(TxValid), 32'd0);
    rd(A_STATUS, 32'h0000_0001, "status_after_reset");
    read_rx("rx_after_reset");

    repeat (3) @(posedge Clock);
    check("rd_sb_drained", 32'(rd_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
